// File: rtl/stack_port_arbiter.sv
// ---------------------------------------------------------------------------
// stack_port_arbiter
//
// Shares data-memory port A between the pipeline's stack-read path and a
// debug/host requester. The pipeline has priority. A debug request that keeps
// losing to the pipeline is counted, and once it has waited max_wait cycles it
// is forced onto the port for one cycle while the pipeline is stalled. The RAM
// has a 1-cycle synchronous read latency, so every debug access is answered in
// the cycle after its grant (S_DRESP). During that cycle the port goes back to
// the pipeline and any debug request is ignored.
//
// Ports
//   clk          clock
//   rst          synchronous, active-high reset
//   pipe_adr     pipeline stack read address
//   pipe_enable  pipeline wants port A this cycle
//   pipe_stall   pipeline access not issued this cycle (forced debug grant)
//   dbg_req      debug request, held with stable adr/we/wdata until dbg_ack
//   dbg_we       debug access type: 1 = write, 0 = read
//   dbg_adr      debug address
//   dbg_wdata    debug write data
//   dbg_ack      one-cycle completion pulse
//   dbg_rdata    debug read data, valid while dbg_ack = 1
//   mem_adr      RAM port A address
//   mem_enable   RAM port A enable
//   mem_we       RAM port A write enable
//   mem_wdata    RAM port A write data
//   mem_rdata    RAM port A read data, 1 cycle after an enabled read
// ---------------------------------------------------------------------------
module stack_port_arbiter #(
    parameter int data_mem_size_in_bits = 30,
    parameter int max_wait              = 8,
    parameter int cnt_bits              = 4
) (
    input  logic                             clk,
    input  logic                             rst,

    input  logic [data_mem_size_in_bits-1:0] pipe_adr,
    input  logic                             pipe_enable,
    output logic                             pipe_stall,

    input  logic                             dbg_req,
    input  logic                             dbg_we,
    input  logic [data_mem_size_in_bits-1:0] dbg_adr,
    input  logic [31:0]                      dbg_wdata,
    output logic                             dbg_ack,
    output logic [31:0]                      dbg_rdata,

    output logic [data_mem_size_in_bits-1:0] mem_adr,
    output logic                             mem_enable,
    output logic                             mem_we,
    output logic [31:0]                      mem_wdata,
    input  logic [31:0]                      mem_rdata
);

    // Elaboration-time guard on the parameter set: the counter has to be able
    // to hold max_wait, and max_wait has to lie between 1 and 15.
    if (max_wait < 1 || max_wait > 15 || max_wait > (2 ** cnt_bits) - 1) begin : g_bad_params
        $error("stack_port_arbiter: max_wait must be 1..15 and fit in cnt_bits");
    end

    typedef enum logic {
        S_PIPE  = 1'b0,   // port owned by the pipeline, debug may be granted
        S_DRESP = 1'b1    // debug response cycle, port back with the pipeline
    } state_t;

    localparam logic [cnt_bits-1:0] LP_MAX_WAIT = cnt_bits'(max_wait);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;
    logic [cnt_bits-1:0] r_starve_cnt;
    logic [cnt_bits-1:0] w_starve_cnt_nxt;
    logic                r_dbg_we;        // access type of the granted request
    logic [31:0]         r_dbg_rdata;     // last debug read result

    // -----------------------------------------------------------------------
    // Grant decision
    // -----------------------------------------------------------------------
    logic w_in_pipe;
    logic w_in_dresp;
    logic w_starved_out;
    logic w_grant_dbg;
    logic w_resp_read;

    assign w_in_pipe     = (r_state == S_PIPE);
    assign w_in_dresp    = (r_state == S_DRESP);
    assign w_starved_out = (r_starve_cnt == LP_MAX_WAIT);

    // The pipeline wins unless it is idle or the debug side has waited long
    // enough. Reset masks the grant so nothing reaches the RAM as debug
    // traffic while rst is high.
    assign w_grant_dbg = ~rst & w_in_pipe & dbg_req & (~pipe_enable | w_starved_out);

    // The response cycle carries RAM data straight through for reads. Reset
    // cancels a response that is in progress.
    assign w_resp_read = ~rst & w_in_dresp & ~r_dbg_we;

    // -----------------------------------------------------------------------
    // Next-state and starvation counter
    // -----------------------------------------------------------------------
    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt      = r_state;
        w_starve_cnt_nxt = r_starve_cnt;

        unique case (r_state)
            S_PIPE: begin
                if (w_grant_dbg) begin
                    w_state_nxt      = S_DRESP;
                    w_starve_cnt_nxt = '0;
                end else if (dbg_req && !w_starved_out) begin
                    // Lost to the pipeline this cycle. Saturates at max_wait,
                    // which is the level that forces the next grant.
                    w_starve_cnt_nxt = r_starve_cnt + 1'b1;
                end
            end
            S_DRESP: begin
                // Single response cycle. Requests seen here are not counted.
                w_state_nxt = S_PIPE;
            end
            default: begin
                w_state_nxt = S_PIPE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before the edge, whatever the block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_PIPE;
            r_starve_cnt <= '0;
            r_dbg_we     <= 1'b0;
            r_dbg_rdata  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_cnt_nxt;
            if (w_grant_dbg) begin
                r_dbg_we <= dbg_we;
            end
            if (w_resp_read) begin
                r_dbg_rdata <= mem_rdata;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Port A mux
    // -----------------------------------------------------------------------
    always_comb begin
        if (w_grant_dbg) begin
            mem_adr    = dbg_adr;
            mem_enable = 1'b1;
            mem_we     = dbg_we;
            mem_wdata  = dbg_wdata;
        end else begin
            // The pipeline only reads through this port.
            mem_adr    = pipe_adr;
            mem_enable = pipe_enable;
            mem_we     = 1'b0;
            mem_wdata  = '0;
        end
    end

    // A stall is only needed when debug takes the port from a live pipeline
    // access, which is the forced-grant case.
    assign pipe_stall = w_grant_dbg & pipe_enable;

    // -----------------------------------------------------------------------
    // Debug response
    // -----------------------------------------------------------------------
    // The ack comes from the state register. It is gated by rst so that a
    // reset arriving in the response cycle removes the pulse in that same
    // cycle.
    assign dbg_ack   = w_in_dresp & ~rst;

    // Reads show the RAM output during the ack cycle and keep it afterwards.
    // A write leaves the previous read result in place.
    assign dbg_rdata = w_resp_read ? mem_rdata : r_dbg_rdata;

endmodule

// File: tb/tb_stack_port_arbiter.sv
module tb_stack_port_arbiter;

    localparam int AW = 30;
    localparam int MW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] pipe_adr = '0;
    logic          pipe_enable = 1'b0;
    logic          pipe_stall;
    logic          dbg_req = 1'b0;
    logic          dbg_we = 1'b0;
    logic [AW-1:0] dbg_adr = '0;
    logic [31:0]   dbg_wdata = '0;
    logic          dbg_ack;
    logic [31:0]   dbg_rdata;
    logic [AW-1:0] mem_adr;
    logic          mem_enable;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    stack_port_arbiter #(
        .data_mem_size_in_bits(AW),
        .max_wait             (MW),
        .cnt_bits             (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_adr   (pipe_adr),
        .pipe_enable(pipe_enable),
        .pipe_stall (pipe_stall),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_adr    (dbg_adr),
        .dbg_wdata  (dbg_wdata),
        .dbg_ack    (dbg_ack),
        .dbg_rdata  (dbg_rdata),
        .mem_adr    (mem_adr),
        .mem_enable (mem_enable),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // RAM on port A: 64K words, 1-cycle synchronous read. Reset reloads it.
    logic [31:0] ram [0:65535];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 65536; i++) ram[i] <= 32'h0;
            ram[16'h0100] <= 32'hDEAD_BEEF;
        end else if (mem_enable) begin
            if (mem_we) ram[mem_adr[15:0]] <= mem_wdata;
            else        mem_rdata <= ram[mem_adr[15:0]];
        end
    end

    // Reference model: who owns the port, how long debug has waited, and
    // which answer is owed. It is evaluated at the negative edge, after the
    // inputs have settled. It then advances to the state after the coming
    // rising edge.
    bit          m_resp = 1'b0;
    bit          m_rd   = 1'b0;
    int          m_cnt  = 0;
    logic [31:0] m_pend = '0;
    logic [31:0] m_last = '0;

    always @(negedge clk) begin
        bit            g;
        logic [AW-1:0] ea;
        logic          ee, ew, es, eack;
        logic [31:0]   ewd, erd;

        if (rst || m_resp) g = 1'b0;
        else               g = dbg_req && (!pipe_enable || m_cnt >= MW);

        ea  = g ? dbg_adr   : pipe_adr;
        ee  = g ? 1'b1      : pipe_enable;
        ew  = g ? dbg_we    : 1'b0;
        ewd = g ? dbg_wdata : 32'h0;
        es  = g && pipe_enable;
        eack = !rst && m_resp;
        erd = (eack && m_rd) ? m_pend : m_last;

        check("m_adr",   64'(mem_adr),    64'(ea));
        check("m_en",    64'(mem_enable), 64'(ee));
        check("m_we",    64'(mem_we),     64'(ew));
        check("m_wdata", 64'(mem_wdata),  64'(ewd));
        check("m_stall", 64'(pipe_stall), 64'(es));
        check("m_ack",   64'(dbg_ack),    64'(eack));
        if (!rst) check("m_rdata", 64'(dbg_rdata), 64'(erd));

        if (rst) begin
            m_resp = 1'b0; m_cnt = 0; m_last = '0;
        end else if (m_resp) begin
            m_last = erd; m_resp = 1'b0;
        end else if (g) begin
            m_resp = 1'b1; m_rd = !dbg_we; m_pend = ram[dbg_adr[15:0]]; m_cnt = 0;
        end else if (dbg_req) begin
            m_cnt = (m_cnt + 1 > MW) ? MW : m_cnt + 1;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Counts the cycles without a stall, up to the one that stalls, and
    // returns at the negative edge of that stall cycle. If no stall comes,
    // the count is returned at its limit so the caller's check fails.
    task automatic count_until_stall(output int n);
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (pipe_stall === 1'b1) return;
            n++;
            next_cycle();
        end
    endtask

    int n;
    int acks, consec, leaks;
    bit prev_ack, ack_seen;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle port: debug read granted immediately.
        pipe_enable = 1'b0; dbg_req = 1'b1; dbg_we = 1'b0; dbg_adr = 30'h100;
        @(negedge clk);
        check("idle_en",    64'(mem_enable), 64'd1);
        check("idle_adr",   64'(mem_adr),    64'h100);
        check("idle_stall", 64'(pipe_stall), 64'd0);
        next_cycle();
        @(negedge clk);
        check("idle_ack",   64'(dbg_ack),    64'd1);
        check("idle_rdata", 64'(dbg_rdata),  64'hDEAD_BEEF);
        next_cycle();
        dbg_req = 1'b0;

        // Starvation: forced write after 8 cycles owned by the pipeline.
        pipe_enable = 1'b1; pipe_adr = 30'h1FF8;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_adr = 30'h40; dbg_wdata = 32'h1234_5678;
        count_until_stall(n);
        check("starve_cycles", 64'(n),         64'd8);
        check("forced_we",     64'(mem_we),    64'd1);
        check("forced_adr",    64'(mem_adr),   64'h40);
        check("forced_wdata",  64'(mem_wdata), 64'h1234_5678);
        next_cycle();
        @(negedge clk);
        check("forced_ack",       64'(dbg_ack),    64'd1);
        check("forced_ack_stall", 64'(pipe_stall), 64'd0);
        next_cycle();
        dbg_req = 1'b0; dbg_we = 1'b0; pipe_enable = 1'b0;

        // Read back the forced write.
        dbg_req = 1'b1; dbg_adr = 30'h40;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        check("rb_ack",   64'(dbg_ack),   64'd1);
        check("rb_rdata", 64'(dbg_rdata), 64'h1234_5678);
        next_cycle();
        dbg_req = 1'b0;

        // Back-to-back: request held high, grants every second cycle.
        dbg_req = 1'b1; dbg_adr = 30'h100; acks = 0; consec = 0; prev_ack = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (dbg_ack) begin
                acks++;
                if (prev_ack) consec++;
            end
            prev_ack = dbg_ack;
            next_cycle();
        end
        check("b2b_acks",   64'(acks),   64'd4);
        check("b2b_consec", 64'(consec), 64'd0);
        dbg_req = 1'b0;

        // Counter hold: 3 starved cycles, drop, reassert -> 5 more.
        pipe_enable = 1'b1; dbg_req = 1'b1;
        repeat (3) next_cycle();
        dbg_req = 1'b0;
        repeat (4) next_cycle();
        dbg_req = 1'b1;
        count_until_stall(n);
        check("hold_resume", 64'(n), 64'd5);
        next_cycle();              // ack cycle
        next_cycle();
        count_until_stall(n);      // counter restarted from 0 after the grant
        check("clear_after_grant", 64'(n), 64'd8);
        next_cycle();
        next_cycle();
        dbg_req = 1'b0;

        // Reset in the response cycle.
        pipe_enable = 1'b0; dbg_req = 1'b1;
        @(negedge clk);
        next_cycle();
        rst = 1'b1; dbg_req = 1'b0;
        @(negedge clk);
        check("rst_ack",   64'(dbg_ack),    64'd0);
        check("rst_stall", 64'(pipe_stall), 64'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ack", 64'(dbg_ack), 64'd0);
        next_cycle();

        // Reset clears a partly counted starvation.
        pipe_enable = 1'b1; dbg_req = 1'b1;
        repeat (3) next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        count_until_stall(n);
        check("rst_clears_cnt", 64'(n), 64'd8);
        next_cycle();
        next_cycle();
        dbg_req = 1'b0;

        // No pipeline write leak: random pipe traffic only.
        leaks = 0;
        repeat (1000) begin
            pipe_enable = 1'($urandom_range(0, 1));
            pipe_adr    = AW'($urandom_range(0, 65535));
            @(negedge clk);
            if (mem_we !== 1'b0 || pipe_stall !== 1'b0 || mem_adr !== pipe_adr) leaks++;
            next_cycle();
        end
        check("no_leak", 64'(leaks), 64'd0);

        // Mixed random traffic with a handshake-respecting debug master.
        ack_seen = 1'b0;
        repeat (2000) begin
            pipe_enable = ($urandom_range(0, 3) != 0);
            pipe_adr    = AW'($urandom_range(0, 65535));
            if (dbg_req && ack_seen) dbg_req = 1'b0;
            if (!dbg_req && $urandom_range(0, 2) == 0) begin
                dbg_req   = 1'b1;
                dbg_we    = 1'($urandom_range(0, 1));
                dbg_adr   = AW'($urandom_range(0, 255));
                dbg_wdata = $urandom;
            end
            @(negedge clk);
            ack_seen = dbg_ack;
            next_cycle();
        end
        dbg_req = 1'b0;
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
